// File: rtl/tone_period_detector.sv
// Measures the clk-cycle period between rising edges of an asynchronous tone and
// declares lock once enough consecutive periods land inside the target window.
module tone_period_detector #(
  parameter int CNT_W         = 20,
  parameter int TARGET_PERIOD = 80000,
  parameter int TOL           = 800,
  parameter int MIN_PERIOD    = 1600,
  parameter int TIMEOUT       = 200000,
  parameter int LOCK_COUNT    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             det_on,
  input  logic             tone_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             in_window,
  output logic             tone_detected,
  output logic             timeout_pulse
);

  typedef enum logic [1:0] {IDLE, WAIT_EDGE, MEASURE, LOCKED} state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W:0]   TARGET_C  = (CNT_W+1)'(TARGET_PERIOD);
  localparam logic [CNT_W:0]   TOL_C     = (CNT_W+1)'(TOL);
  localparam logic [CNT_W:0]   MIN_C     = (CNT_W+1)'(MIN_PERIOD);
  localparam logic [3:0]       LOCK_C    = 4'(LOCK_COUNT);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] period_reg, period_next;
  logic [3:0]       match_reg, match_next;
  logic             pv_reg, pv_next;
  logic             inw_reg, inw_next;
  logic             to_reg, to_next;
  logic             s1_reg, s2_reg, s3_reg;

  logic             edge_det;
  logic [CNT_W:0]   p_meas;
  logic [CNT_W:0]   p_diff;
  logic             p_in_win;
  logic [3:0]       match_inc;

  // Period is one more than the count because cnt is cleared on the edge cycle.
  assign edge_det  = s2_reg & ~s3_reg;
  assign p_meas    = {1'b0, cnt_reg} + (CNT_W+1)'(1);
  assign p_diff    = (p_meas >= TARGET_C) ? (p_meas - TARGET_C) : (TARGET_C - p_meas);
  assign p_in_win  = (p_diff <= TOL_C);
  assign match_inc = (match_reg < LOCK_C) ? (match_reg + 4'd1) : match_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      period_reg <= '0;
      match_reg  <= '0;
      pv_reg     <= 1'b0;
      inw_reg    <= 1'b0;
      to_reg     <= 1'b0;
      s1_reg     <= 1'b0;
      s2_reg     <= 1'b0;
      s3_reg     <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      period_reg <= period_next;
      match_reg  <= match_next;
      pv_reg     <= pv_next;
      inw_reg    <= inw_next;
      to_reg     <= to_next;
      s1_reg     <= tone_in;
      s2_reg     <= s1_reg;
      s3_reg     <= s2_reg;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    period_next = period_reg;
    match_next  = match_reg;
    inw_next    = inw_reg;
    pv_next     = 1'b0;
    to_next     = 1'b0;
    if (!det_on) begin
      state_next  = IDLE;
      cnt_next    = '0;
      period_next = '0;
      match_next  = '0;
      inw_next    = 1'b0;
    end else begin
      case (state_reg)
        IDLE: state_next = WAIT_EDGE;
        WAIT_EDGE: begin
          cnt_next = '0;
          if (edge_det) state_next = MEASURE;
        end
        MEASURE, LOCKED: begin
          // A real edge beats a coincident timeout; glitch edges fall through to counting.
          if (edge_det && (p_meas >= MIN_C)) begin
            period_next = p_meas[CNT_W-1:0];
            pv_next     = 1'b1;
            inw_next    = p_in_win;
            cnt_next    = '0;
            if (p_in_win) begin
              match_next = match_inc;
              if (match_inc == LOCK_C) state_next = LOCKED;
            end else begin
              match_next = '0;
              state_next = MEASURE;
            end
          end else if (!edge_det && (cnt_reg == TIMEOUT_C)) begin
            to_next    = 1'b1;
            inw_next   = 1'b0;
            match_next = '0;
            cnt_next   = '0;
            state_next = WAIT_EDGE;
          end else if (cnt_reg != TIMEOUT_C) begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign period        = period_reg;
  assign period_valid  = pv_reg;
  assign in_window     = inw_reg;
  assign timeout_pulse = to_reg;
  assign tone_detected = (state_reg == LOCKED);

endmodule

// File: tb/tb_tone_period_detector.sv
// Drives tone rises at known cycles and checks every strobe/timeout against an
// event-level model of expected periods, window decisions and lock status.
module tb_tone_period_detector;

  localparam int CNT_W  = 12;
  localparam int TARGET = 800;
  localparam int TOL    = 8;
  localparam int MINP   = 100;
  localparam int TMO    = 2000;
  localparam int LOCK   = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             det_on = 1'b0;
  logic             tone_in = 1'b0;
  logic [CNT_W-1:0] period;
  logic             period_valid, in_window, tone_detected, timeout_pulse;

  tone_period_detector #(
    .CNT_W(CNT_W), .TARGET_PERIOD(TARGET), .TOL(TOL),
    .MIN_PERIOD(MINP), .TIMEOUT(TMO), .LOCK_COUNT(LOCK)
  ) dut (
    .clk(clk), .reset(reset), .det_on(det_on), .tone_in(tone_in),
    .period(period), .period_valid(period_valid), .in_window(in_window),
    .tone_detected(tone_detected), .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int kind;   // 0 = period strobe, 1 = timeout
    int per;
    int inw;
    int det;
  } ev_t;

  ev_t obs_q[$];
  ev_t exp_q[$];
  int  both_high = 0;

  always @(negedge clk) begin
    if (period_valid && timeout_pulse) both_high <= both_high + 1;
    if (period_valid)
      obs_q.push_back(ev_t'{cyc, 0, int'(period), int'(in_window), int'(tone_detected)});
    if (timeout_pulse)
      obs_q.push_back(ev_t'{cyc, 1, int'(period), int'(in_window), int'(tone_detected)});
  end

  int vectors = 0;
  int miscompares = 0;

  // Reference model: 0 = off, 1 = waiting for first edge, 2 = measuring
  int m_state = 0;
  int m_last = 0;
  int m_match = 0;
  int m_lastper = 0;
  int m_locked = 0;

  task automatic chk(input string tag, input int obs, input int expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_timeout_at(input int t_last);
    exp_q.push_back(ev_t'{t_last + TMO + 4, 1, m_lastper, 0, 0});
    m_state = 1; m_match = 0; m_locked = 0;
  endtask

  // t is the cycle the rise is driven; the detector reports it 3 cycles later.
  task automatic model_rise(input int t);
    int d;
    int inw;
    if (m_state == 2 && (t - m_last) > TMO + 1) model_timeout_at(m_last);
    if (m_state == 0) return;
    if (m_state == 1) begin
      m_state = 2; m_last = t;
      return;
    end
    d = t - m_last;
    if (d < MINP) return;
    inw = (d >= TARGET - TOL && d <= TARGET + TOL) ? 1 : 0;
    if (inw == 1) begin
      if (m_match < LOCK) m_match++;
      if (m_match == LOCK) m_locked = 1;
    end else begin
      m_match = 0; m_locked = 0;
    end
    m_lastper = d;
    exp_q.push_back(ev_t'{t + 3, 0, d, inw, m_locked});
    m_last = t;
  endtask

  task automatic model_flush(input int now);
    if (m_state == 2 && (now - m_last) >= TMO + 5) model_timeout_at(m_last);
  endtask

  task automatic model_clear(input int next_state);
    m_state = next_state; m_match = 0; m_locked = 0; m_lastper = 0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tone_cycle(input int d);
    model_rise(cyc);
    tone_in = 1'b1;
    wait_cyc(d / 2);
    tone_in = 1'b0;
    wait_cyc(d - d / 2);
  endtask

  // Main rise, a 10-cycle dip, then a spurious rise 50 cycles after the real one.
  task automatic glitch_cycle(input int d);
    model_rise(cyc);
    tone_in = 1'b1;
    wait_cyc(40);
    tone_in = 1'b0;
    wait_cyc(10);
    model_rise(cyc);
    tone_in = 1'b1;
    wait_cyc(d / 2 - 50);
    tone_in = 1'b0;
    wait_cyc(d - d / 2);
  endtask

  task automatic compare_events(input string tag);
    int n;
    chk({tag, "/count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s/%0d kind", tag, i), obs_q[i].kind, exp_q[i].kind);
      chk($sformatf("%s/%0d cycle", tag, i), obs_q[i].cyc, exp_q[i].cyc);
      chk($sformatf("%s/%0d period", tag, i), obs_q[i].per, exp_q[i].per);
      chk($sformatf("%s/%0d in_window", tag, i), obs_q[i].inw, exp_q[i].inw);
      chk($sformatf("%s/%0d tone_detected", tag, i), obs_q[i].det, exp_q[i].det);
      $display("[%s] event %0d kind=%0d cyc=%0d period=%0d inw=%0d det=%0d",
               tag, i, obs_q[i].kind, obs_q[i].cyc, obs_q[i].per, obs_q[i].inw, obs_q[i].det);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "/period"}, int'(period), 0);
    chk({tag, "/period_valid"}, int'(period_valid), 0);
    chk({tag, "/in_window"}, int'(in_window), 0);
    chk({tag, "/tone_detected"}, int'(tone_detected), 0);
    chk({tag, "/timeout_pulse"}, int'(timeout_pulse), 0);
  endtask

  initial begin
    @(posedge clk);
    #1;
    wait_cyc(3);
    check_all_zero("reset");
    reset = 1'b0;
    wait_cyc(2);
    check_all_zero("idle");

    // Steady target tone: lock on the 4th strobe
    det_on = 1'b1;
    m_state = 1;
    wait_cyc(2);
    repeat (8) tone_cycle(TARGET);
    compare_events("target");
    chk("target/locked", int'(tone_detected), 1);

    // Double-frequency tone never locks
    repeat (6) tone_cycle(TARGET / 2);
    compare_events("double_freq");
    chk("double_freq/locked", int'(tone_detected), 0);

    // Relock, then a glitch rise shorter than MIN_PERIOD is ignored
    repeat (5) tone_cycle(TARGET);
    glitch_cycle(TARGET);
    repeat (2) tone_cycle(TARGET);
    compare_events("glitch");
    chk("glitch/locked", int'(tone_detected), 1);

    // Window boundaries on both sides
    tone_cycle(TARGET + TOL);
    tone_cycle(TARGET + TOL + 1);
    tone_cycle(TARGET - TOL);
    tone_cycle(TARGET - TOL - 1);
    tone_cycle(TARGET);
    compare_events("boundary");

    // Randomized periods around the window, occasionally with a glitch
    for (int i = 0; i < 12; i++) begin
      int d;
      d = int'($urandom_range(TARGET + 3 * TOL, TARGET - 3 * TOL));
      if ($urandom_range(3, 0) == 0) glitch_cycle(d);
      else tone_cycle(d);
    end
    compare_events("random");

    // Lock, then stop the tone and expect exactly one timeout
    repeat (6) tone_cycle(TARGET);
    wait_cyc(TMO + 60);
    model_flush(cyc);
    compare_events("timeout");
    chk("timeout/period_kept", int'(period), m_lastper);
    chk("timeout/locked", int'(tone_detected), 0);

    // Edge coincident with timeout wins; one cycle later the timeout wins
    tone_cycle(TARGET);
    tone_cycle(TMO + 1);
    tone_cycle(TMO + 2);
    tone_cycle(TARGET);
    compare_events("edge_vs_timeout");

    // Reset while locked
    repeat (5) tone_cycle(TARGET);
    chk("pre_reset/locked", int'(tone_detected), m_locked);
    compare_events("pre_reset");
    reset = 1'b1;
    wait_cyc(1);
    reset = 1'b0;
    check_all_zero("mid_reset");
    model_clear(1);

    // det_on drop while locked
    wait_cyc(2);
    repeat (5) tone_cycle(TARGET);
    chk("pre_disable/locked", int'(tone_detected), m_locked);
    compare_events("pre_disable");
    det_on = 1'b0;
    wait_cyc(1);
    check_all_zero("disable");
    model_clear(0);
    wait_cyc(5);
    det_on = 1'b1;
    model_clear(1);
    wait_cyc(2);
    repeat (4) tone_cycle(TARGET);
    chk("relock/after4", int'(tone_detected), 0);
    tone_cycle(TARGET);
    chk("relock/after5", int'(tone_detected), 1);
    compare_events("relock");

    chk("pv_tp_overlap", both_high, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
